clk_period_meter: RTL and testbench

- Receive side of the divided-clock path. Takes a slow, asynchronous clock-like signal, such as the output of the team's clock divider or an external reference.
- Measures that signal in clkIn cycles:
  - full period, rising edge to rising edge;
  - high time, rising edge to falling edge.
- Reports lock when consecutive periods agree, and flags a stall when edges stop arriving.
- Used to check divider settings on hardware and to feed measured rates to the processor's status logic.

---
 rtl/clk_period_meter.sv | 205 ++++++++++++++++++++
 tb/tb_clk_period_meter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
// Receive side of the divided-clock path. Measures a slow, asynchronous
// clock-like input in clkIn cycles: full period (rise to rise) and high
// time (rise to fall). Reports lock when consecutive periods agree within
// TOL cycles, and flags a stall when rising edges stop arriving.

module clk_period_meter #(
    parameter int CNT_W       = 26,        // counter and measurement width
    parameter int TIMEOUT     = 60000000,  // cycles without a rise before stall; < 2**CNT_W
    parameter int TOL         = 1,         // max |period delta| that still counts as a match
    parameter int SYNC_STAGES = 2          // synchronizer depth on sigIn, minimum 2
) (
    input  logic             clkIn,
    input  logic             rstN,
    input  logic             sigIn,
    input  logic             clr,
    output logic [CNT_W-1:0] periodOut,
    output logic [CNT_W-1:0] highOut,
    output logic             valid,
    output logic             locked,
    output logic             stalled
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first rise after reset, clr or stall
        MEAS  = 2'd1,   // at least one rise seen, measuring periods
        STALL = 2'd2    // no rise for TIMEOUT cycles
    } stateT;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);

    // Synchronizer chain and edge history
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   sigPrev;
    logic                   sigSync;
    logic                   rise;
    logic                   fall;

    // Cycle counter and period history
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       prevPeriod;
    logic                   havePrev;

    // Tolerance compare, one bit wider than the counter so it cannot wrap
    logic [CNT_W:0]         cntExt;
    logic [CNT_W:0]         prevExt;
    logic [CNT_W:0]         diffAbs;
    logic                   periodMatch;
    logic                   timeoutHit;

    // Control
    stateT                  state;
    logic                   validPend;

    // Bring sigIn into the clkIn domain through SYNC_STAGES flops.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            syncQ <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what builds the chain.
            syncQ <= {syncQ[SYNC_STAGES-2:0], sigIn};
        end
    end

    // Keep the synchronized level from one cycle earlier for edge detection.
    // The edge history keeps tracking through clr so that a level which is
    // already high when clr drops is not mistaken for a fresh rise.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            sigPrev <= 1'b0;
        end else begin
            sigPrev <= sigSync;
        end
    end

    assign sigSync = syncQ[SYNC_STAGES-1];
    assign rise    = sigSync & ~sigPrev;
    assign fall    = ~sigSync & sigPrev;

    // Free-running cycle counter: restarts at 1 on each rise, so at the next
    // rise it holds the distance between the two rises. Saturates so a dead
    // input never wraps around into a plausible-looking period.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Absolute difference between the period just completed and the last one.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path
        // through the block leaves one holding its old value (no latch).
        cntExt  = {1'b0, cnt};
        prevExt = {1'b0, prevPeriod};
        diffAbs = '0;
        if (cntExt >= prevExt) begin
            diffAbs = cntExt - prevExt;
        end else begin
            diffAbs = prevExt - cntExt;
        end
    end

    assign periodMatch = havePrev && (diffAbs <= TOL_EXT);

    // A rise in the same cycle wins over the timeout.
    assign timeoutHit  = (cnt == TIMEOUT_CNT) && !rise;

    // Measurement FSM with registered outputs. Priority: clr > rise > timeout.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            periodOut  <= '0;
            highOut    <= '0;
            validPend  <= 1'b0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
            prevPeriod <= '0;
            havePrev   <= 1'b0;
        end else if (clr) begin
            // A rise coinciding with clr is deliberately dropped.
            state      <= IDLE;
            periodOut  <= '0;
            highOut    <= '0;
            validPend  <= 1'b0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
            prevPeriod <= '0;
            havePrev   <= 1'b0;
        end else begin
            // valid trails the periodOut update by one cycle; periodOut holds,
            // so it is already stable while valid is high.
            valid     <= validPend;
            validPend <= 1'b0;

            case (state)
                IDLE: begin
                    // The first rise only opens a period; nothing to report yet.
                    if (rise) begin
                        state <= MEAS;
                    end else if (timeoutHit) begin
                        state      <= STALL;
                        stalled    <= 1'b1;
                        periodOut  <= '0;
                        highOut    <= '0;
                        locked     <= 1'b0;
                        prevPeriod <= '0;
                        havePrev   <= 1'b0;
                    end
                end

                MEAS: begin
                    if (rise) begin
                        periodOut  <= cnt;
                        validPend  <= 1'b1;
                        locked     <= periodMatch;
                        prevPeriod <= cnt;
                        havePrev   <= 1'b1;
                    end else begin
                        // MEAS is only ever entered on a rise, so any fall seen
                        // here closes a high phase that started inside MEAS.
                        if (fall) begin
                            highOut <= cnt;
                        end
                        if (timeoutHit) begin
                            state      <= STALL;
                            stalled    <= 1'b1;
                            periodOut  <= '0;
                            highOut    <= '0;
                            locked     <= 1'b0;
                            prevPeriod <= '0;
                            havePrev   <= 1'b0;
                            validPend  <= 1'b0;
                            valid      <= 1'b0;
                        end
                    end
                end

                STALL: begin
                    // Recovery rise restarts the period but reports nothing;
                    // the first period after a stall needs a second rise.
                    if (rise) begin
                        state   <= MEAS;
                        stalled <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed testbench for clk_period_meter with TIMEOUT=100, TOL=1,
// SYNC_STAGES=2. sigIn and clr change on the falling edge of clkIn and
// outputs are sampled on the falling edge, away from the active rising edge.

module tb_clk_period_meter;

    localparam int CNT_W   = 26;
    localparam int TIMEOUT = 100;
    localparam int TOL     = 1;
    localparam int SYNC    = 2;

    logic             clkIn = 1'b0;
    logic             rstN;
    logic             sigIn;
    logic             clr;
    logic [CNT_W-1:0] periodOut;
    logic [CNT_W-1:0] highOut;
    logic             valid;
    logic             locked;
    logic             stalled;

    int vectors     = 0;
    int miscompares = 0;

    // What drivePeriod saw on the valid pulse inside its period
    int               vCount;
    int               vIdx;
    logic [CNT_W-1:0] vPer;
    logic [CNT_W-1:0] vHigh;
    logic             vLock;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .TOL        (TOL),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clkIn    (clkIn),
        .rstN     (rstN),
        .sigIn    (sigIn),
        .clr      (clr),
        .periodOut(periodOut),
        .highOut  (highOut),
        .valid    (valid),
        .locked   (locked),
        .stalled  (stalled)
    );

    always #5 clkIn = ~clkIn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // One period of sigIn: high for hi cycles, low for the rest. clr is
    // pulsed in iteration clrAt (-1 for never). Iteration i samples the
    // outputs produced by the i-th clkIn edge after sigIn went high, so a
    // valid caused by this period's rise shows up at i = SYNC+1.
    task automatic drivePeriod(input int per, input int hi, input int clrAt);
        vCount = 0;
        vIdx   = -1;
        vPer   = '0;
        vHigh  = '0;
        vLock  = 1'b0;
        for (int i = 0; i < per; i++) begin
            sigIn = (i < hi);
            clr   = (i == clrAt);
            @(negedge clkIn);
            if (valid) begin
                if (vCount == 0) begin
                    vIdx  = i;
                    vPer  = periodOut;
                    vHigh = highOut;
                    vLock = locked;
                end
                vCount++;
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstN  = 1'b0;
        sigIn = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clkIn);
        vectors++; if (periodOut !== '0) begin miscompares++; $display("FAIL reset.periodOut: got %0d want 0", periodOut); end
        vectors++; if (highOut !== '0)   begin miscompares++; $display("FAIL reset.highOut: got %0d want 0", highOut); end
        vectors++; if (valid !== 1'b0)   begin miscompares++; $display("FAIL reset.valid: got %b want 0", valid); end
        vectors++; if (locked !== 1'b0)  begin miscompares++; $display("FAIL reset.locked: got %b want 0", locked); end
        vectors++; if (stalled !== 1'b0) begin miscompares++; $display("FAIL reset.stalled: got %b want 0", stalled); end
        rstN = 1'b1;
    endtask

    // cnt is 0 out of reset, reaches TIMEOUT after edge 100 and the stall
    // registers on edge 101.
    task automatic test_idle_timeout();
        int sawValid;
        sawValid = 0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clkIn);
            if (valid) sawValid++;
            if (k == 99) begin
                vectors++; if (stalled !== 1'b0) begin miscompares++; $display("FAIL idle.stalled_early: got %b want 0", stalled); end
            end
            if (k == 101) begin
                vectors++; if (stalled !== 1'b1)  begin miscompares++; $display("FAIL idle.stalled: got %b want 1", stalled); end
                vectors++; if (periodOut !== '0)  begin miscompares++; $display("FAIL idle.periodOut: got %0d want 0", periodOut); end
            end
        end
        vectors++; if (sawValid !== 0) begin miscompares++; $display("FAIL idle.valid_seen: got %0d want 0", sawValid); end
    endtask

    // Table of periods: each valid reports the length of the previous row.
    task automatic test_steady();
        int per[3]  = '{10, 10, 10};
        int hi[3]   = '{4, 4, 4};
        int eCnt[3] = '{0, 1, 1};
        int ePer[3] = '{0, 10, 10};
        int eHi[3]  = '{0, 4, 4};
        int eLk[3]  = '{0, 0, 1};
        clr = 1'b1;
        @(negedge clkIn);
        clr = 1'b0;
        vectors++; if (stalled !== 1'b0) begin miscompares++; $display("FAIL steady.clr_stalled: got %b want 0", stalled); end
        for (int r = 0; r < 3; r++) begin
            drivePeriod(per[r], hi[r], -1);
            vectors++; if (vCount !== eCnt[r]) begin miscompares++; $display("FAIL steady[%0d].count: got %0d want %0d", r, vCount, eCnt[r]); end
            if (eCnt[r] != 0) begin
                vectors++; if (vPer !== CNT_W'(ePer[r]))  begin miscompares++; $display("FAIL steady[%0d].period: got %0d want %0d", r, vPer, ePer[r]); end
                vectors++; if (vHigh !== CNT_W'(eHi[r]))  begin miscompares++; $display("FAIL steady[%0d].high: got %0d want %0d", r, vHigh, eHi[r]); end
                vectors++; if (vLock !== 1'(eLk[r]))      begin miscompares++; $display("FAIL steady[%0d].locked: got %b want %0d", r, vLock, eLk[r]); end
                vectors++; if (vIdx !== SYNC + 1)         begin miscompares++; $display("FAIL steady[%0d].latency: got %0d want %0d", r, vIdx, SYNC + 1); end
            end
        end
    endtask

    task automatic test_period_change();
        int per[8]  = '{14, 14, 14, 10, 10, 11, 10, 10};
        int hi[8]   = '{4, 4, 6, 4, 4, 5, 4, 4};
        int ePer[8] = '{10, 14, 14, 14, 10, 10, 11, 10};
        int eHi[8]  = '{4, 4, 4, 6, 4, 4, 5, 4};
        int eLk[8]  = '{1, 0, 1, 1, 0, 1, 1, 1};
        for (int r = 0; r < 8; r++) begin
            drivePeriod(per[r], hi[r], -1);
            vectors++; if (vCount !== 1)             begin miscompares++; $display("FAIL change[%0d].count: got %0d want 1", r, vCount); end
            vectors++; if (vPer !== CNT_W'(ePer[r])) begin miscompares++; $display("FAIL change[%0d].period: got %0d want %0d", r, vPer, ePer[r]); end
            vectors++; if (vHigh !== CNT_W'(eHi[r])) begin miscompares++; $display("FAIL change[%0d].high: got %0d want %0d", r, vHigh, eHi[r]); end
            vectors++; if (vLock !== 1'(eLk[r]))     begin miscompares++; $display("FAIL change[%0d].locked: got %b want %0d", r, vLock, eLk[r]); end
        end
    endtask

    // The last rise is taken on edge 2 of this period (two synchronizer
    // stages), so the stall must appear exactly 100 edges later, on edge 102.
    task automatic test_stall();
        int stallIdx;
        int nValid;
        logic [CNT_W-1:0] seenPer;
        stallIdx = -1;
        nValid   = 0;
        seenPer  = '0;
        for (int i = 0; i < 120; i++) begin
            sigIn = (i < 4);
            @(negedge clkIn);
            if (valid) begin nValid++; seenPer = periodOut; end
            if (stalled && stallIdx < 0) stallIdx = i;
        end
        vectors++; if (nValid !== 1)            begin miscompares++; $display("FAIL stall.valid_count: got %0d want 1", nValid); end
        vectors++; if (seenPer !== CNT_W'(10))  begin miscompares++; $display("FAIL stall.last_period: got %0d want 10", seenPer); end
        vectors++; if (stallIdx !== 2 + TIMEOUT) begin miscompares++; $display("FAIL stall.edge: got %0d want %0d", stallIdx, 2 + TIMEOUT); end
        vectors++; if (stalled !== 1'b1)        begin miscompares++; $display("FAIL stall.stalled: got %b want 1", stalled); end
        vectors++; if (locked !== 1'b0)         begin miscompares++; $display("FAIL stall.locked: got %b want 0", locked); end
        vectors++; if (periodOut !== '0)        begin miscompares++; $display("FAIL stall.periodOut: got %0d want 0", periodOut); end
        vectors++; if (highOut !== '0)          begin miscompares++; $display("FAIL stall.highOut: got %0d want 0", highOut); end

        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 0)     begin miscompares++; $display("FAIL recover.first_count: got %0d want 0", vCount); end
        vectors++; if (stalled !== 1'b0) begin miscompares++; $display("FAIL recover.stalled: got %b want 0", stalled); end
        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 1)           begin miscompares++; $display("FAIL recover.count: got %0d want 1", vCount); end
        vectors++; if (vPer !== CNT_W'(10))    begin miscompares++; $display("FAIL recover.period: got %0d want 10", vPer); end
        vectors++; if (vHigh !== CNT_W'(4))    begin miscompares++; $display("FAIL recover.high: got %0d want 4", vHigh); end
        vectors++; if (vLock !== 1'b0)         begin miscompares++; $display("FAIL recover.locked: got %b want 0", vLock); end
    endtask

    // clr lands on edge 2, the same edge that takes the rise.
    task automatic test_clear_collision();
        drivePeriod(10, 4, SYNC);
        vectors++; if (vCount !== 0)     begin miscompares++; $display("FAIL clr.valid_count: got %0d want 0", vCount); end
        vectors++; if (periodOut !== '0) begin miscompares++; $display("FAIL clr.periodOut: got %0d want 0", periodOut); end
        vectors++; if (highOut !== '0)   begin miscompares++; $display("FAIL clr.highOut: got %0d want 0", highOut); end
        vectors++; if (locked !== 1'b0)  begin miscompares++; $display("FAIL clr.locked: got %b want 0", locked); end
        vectors++; if (stalled !== 1'b0) begin miscompares++; $display("FAIL clr.stalled: got %b want 0", stalled); end
        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 0) begin miscompares++; $display("FAIL clr.next1_count: got %0d want 0", vCount); end
        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 1)        begin miscompares++; $display("FAIL clr.next2_count: got %0d want 1", vCount); end
        vectors++; if (vPer !== CNT_W'(10)) begin miscompares++; $display("FAIL clr.next2_period: got %0d want 10", vPer); end
        vectors++; if (vHigh !== CNT_W'(4)) begin miscompares++; $display("FAIL clr.next2_high: got %0d want 4", vHigh); end
    endtask

    task automatic test_reset_mid();
        drivePeriod(10, 4, -1);
        vectors++; if (vLock !== 1'b1) begin miscompares++; $display("FAIL rstmid.pre_locked: got %b want 1", vLock); end
        // First half of the next period, then reset between clock edges.
        drivePeriod(5, 4, -1);
        #2 rstN = 1'b0;
        #1;
        vectors++; if (periodOut !== '0) begin miscompares++; $display("FAIL rstmid.periodOut: got %0d want 0", periodOut); end
        vectors++; if (highOut !== '0)   begin miscompares++; $display("FAIL rstmid.highOut: got %0d want 0", highOut); end
        vectors++; if (locked !== 1'b0)  begin miscompares++; $display("FAIL rstmid.locked: got %b want 0", locked); end
        vectors++; if (valid !== 1'b0)   begin miscompares++; $display("FAIL rstmid.valid: got %b want 0", valid); end
        #1 rstN = 1'b1;
        drivePeriod(5, 0, -1);
        vectors++; if (vCount !== 0) begin miscompares++; $display("FAIL rstmid.tail_count: got %0d want 0", vCount); end
        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 0) begin miscompares++; $display("FAIL rstmid.first_count: got %0d want 0", vCount); end
        drivePeriod(10, 4, -1);
        vectors++; if (vCount !== 1)        begin miscompares++; $display("FAIL rstmid.second_count: got %0d want 1", vCount); end
        vectors++; if (vPer !== CNT_W'(10)) begin miscompares++; $display("FAIL rstmid.period: got %0d want 10", vPer); end
        vectors++; if (vHigh !== CNT_W'(4)) begin miscompares++; $display("FAIL rstmid.high: got %0d want 4", vHigh); end
        vectors++; if (vLock !== 1'b0)      begin miscompares++; $display("FAIL rstmid.locked_after: got %b want 0", vLock); end
    endtask

    initial begin
        test_reset();
        test_idle_timeout();
        test_steady();
        test_period_change();
        test_stall();
        test_clear_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
